// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-master arbiter and access sequencer for the shared data memory.
// In IDLE it latches one request, drives it to the DM for WAIT_CYCLES+1 cycles, then pulses rdy.
module dm_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_type,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic [31:0] m0_pc,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_type,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic [31:0] m1_pc,
    output logic        m0_rdy,
    output logic [31:0] m0_rd,
    output logic        m0_err,
    output logic        m1_rdy,
    output logic [31:0] m1_rd,
    output logic        m1_err,
    output logic        s_we,
    output logic [3:0]  s_type,
    output logic [31:0] s_addr,
    output logic [31:0] s_wd,
    output logic [31:0] s_pc,
    input  logic [31:0] s_rd,
    input  logic        s_exc,
    output logic        busy
);
    typedef struct packed {
        logic        we;
        logic [3:0]  typ;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pc;
    } dm_req_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        grant, grant_nx;
    dm_req_t     req_q, req_nx;
    dm_req_t     m0_pkt, m1_pkt;
    logic [31:0] rd_q;
    logic        err_q;
    logic        in_access, final_cyc;

    assign m0_pkt = '{we: m0_we, typ: m0_type, addr: m0_addr, wd: m0_wd, pc: m0_pc};
    assign m1_pkt = '{we: m1_we, typ: m1_type, addr: m1_addr, wd: m1_wd, pc: m1_pc};

    assign in_access = (state == ACCESS);
    assign final_cyc = in_access && (cnt == 4'd0);

    // grant doubles as last_grant: it only changes on a new grant and resets to 1,
    // so master 0 wins the first tie.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        grant_nx = grant;
        req_nx   = req_q;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_nx = (m0_req && m1_req) ? ~grant : m1_req;
                    req_nx   = grant_nx ? m1_pkt : m0_pkt;
                    cnt_nx   = WAIT_INIT;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
                else             state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            grant <= 1'b1;
            req_q <= '0;
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            grant <= grant_nx;
            req_q <= req_nx;
            if (final_cyc) begin
                rd_q  <= s_rd;
                err_q <= s_exc;
            end
        end
    end

    // Write enable only on the last ACCESS cycle so each store hits the DM exactly once.
    assign s_we   = final_cyc & req_q.we;
    assign s_type = in_access ? req_q.typ  : '0;
    assign s_addr = in_access ? req_q.addr : '0;
    assign s_wd   = in_access ? req_q.wd   : '0;
    assign s_pc   = in_access ? req_q.pc   : '0;

    assign m0_rdy = (state == DONE) && !grant;
    assign m1_rdy = (state == DONE) && grant;
    assign m0_rd  = m0_rdy ? rd_q : '0;
    assign m1_rd  = m1_rdy ? rd_q : '0;
    assign m0_err = m0_rdy & err_q;
    assign m1_err = m1_rdy & err_q;
    assign busy   = (state != IDLE);
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: cycle-phase model of the WAIT_CYCLES=1 instance checked every cycle,
// plus directed vectors with literal expectations on both the WAIT_CYCLES=1 and =0 instances.
module tb_dm_arbiter;
    localparam int W = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [3:0]  m0_type = 0, m1_type = 0;
    logic [31:0] m0_addr = 0, m0_wd = 0, m0_pc = 0, m1_addr = 0, m1_wd = 0, m1_pc = 0;
    logic        m0_rdy, m0_err, m1_rdy, m1_err, s_we, s_exc, busy;
    logic [31:0] m0_rd, m1_rd, s_addr, s_wd, s_pc, s_rd;
    logic [3:0]  s_type;

    logic        m1_req_b = 0, zero1 = 0;
    logic [3:0]  m1_type_b = 0, zero4 = 0;
    logic [31:0] m1_addr_b = 0, zero32 = 0;
    logic        m0_rdy_b, m0_err_b, m1_rdy_b, m1_err_b, s_we_b, busy_b;
    logic [31:0] m0_rd_b, m1_rd_b, s_addr_b, s_wd_b, s_pc_b, s_rd_b;
    logic [3:0]  s_type_b;

    dm_arbiter #(.WAIT_CYCLES(W)) u0 (
        .clk(clk), .reset(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_type(m0_type), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_pc(m0_pc),
        .m1_req(m1_req), .m1_we(m1_we), .m1_type(m1_type), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_pc(m1_pc),
        .m0_rdy(m0_rdy), .m0_rd(m0_rd), .m0_err(m0_err), .m1_rdy(m1_rdy), .m1_rd(m1_rd), .m1_err(m1_err),
        .s_we(s_we), .s_type(s_type), .s_addr(s_addr), .s_wd(s_wd), .s_pc(s_pc),
        .s_rd(s_rd), .s_exc(s_exc), .busy(busy)
    );

    dm_arbiter #(.WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(rst),
        .m0_req(zero1), .m0_we(zero1), .m0_type(zero4), .m0_addr(zero32), .m0_wd(zero32), .m0_pc(zero32),
        .m1_req(m1_req_b), .m1_we(zero1), .m1_type(m1_type_b), .m1_addr(m1_addr_b), .m1_wd(zero32), .m1_pc(zero32),
        .m0_rdy(m0_rdy_b), .m0_rd(m0_rd_b), .m0_err(m0_err_b), .m1_rdy(m1_rdy_b), .m1_rd(m1_rd_b), .m1_err(m1_err_b),
        .s_we(s_we_b), .s_type(s_type_b), .s_addr(s_addr_b), .s_wd(s_wd_b), .s_pc(s_pc_b),
        .s_rd(s_rd_b), .s_exc(1'b0), .busy(busy_b)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic misal(input logic [3:0] t, input logic [31:0] a);
        case (t)
            4'b0000:          return a[1:0] != 2'b00;
            4'b0010, 4'b0011: return a[0];
            default:          return 1'b0;
        endcase
    endfunction

    // Simple DM: stores land as whole words (sub-word merge is not needed by these vectors).
    logic [31:0] mem [0:63];
    int we_cnt = 0;
    assign s_rd   = mem[s_addr[7:2]];
    assign s_exc  = misal(s_type, s_addr);
    assign s_rd_b = s_addr_b ^ 32'h5A5A_0000;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (s_we && !s_exc) begin
            mem[s_addr[7:2]] <= s_wd;
        end
        if (s_we) we_cnt++;
    end

    // Model: m_ph counts cycles since the grant (0 = idle, 1..W+1 = access, W+2 = rdy).
    int          m_ph = 0;
    int          cyc = 0;
    logic        m_g, m_last = 1'b1, m_we;
    logic [3:0]  m_typ;
    logic [31:0] m_addr, m_wd, m_pc, exp_rd = 0;
    logic        exp_err = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph   = 0;
            m_last = 1'b1;
        end else if (m_ph == 0) begin
            if (m0_req || m1_req) begin
                m_g    = (m0_req && m1_req) ? !m_last : m1_req;
                m_last = m_g;
                m_we   = m_g ? m1_we   : m0_we;
                m_typ  = m_g ? m1_type : m0_type;
                m_addr = m_g ? m1_addr : m0_addr;
                m_wd   = m_g ? m1_wd   : m0_wd;
                m_pc   = m_g ? m1_pc   : m0_pc;
                m_ph   = 1;
            end
        end else if (m_ph == W + 2) begin
            m_ph = 0;
        end else begin
            m_ph++;
        end
    end

    int          rq_cyc[$];
    logic        rq_who[$];
    logic [31:0] rq_dat[$];

    always @(negedge clk) begin
        logic acc, done;
        acc  = (m_ph >= 1) && (m_ph <= W + 1);
        done = (m_ph == W + 2);
        if (m_ph == W + 1) begin
            exp_rd  = mem[m_addr[7:2]];
            exp_err = misal(m_typ, m_addr);
        end
        chk("busy",   {31'd0, busy},   {31'd0, m_ph != 0});
        chk("s_we",   {31'd0, s_we},   {31'd0, acc && m_ph == W + 1 && m_we});
        chk("s_type", {28'd0, s_type}, acc ? {28'd0, m_typ} : 32'd0);
        chk("s_addr", s_addr, acc ? m_addr : 32'd0);
        chk("s_wd",   s_wd,   acc ? m_wd   : 32'd0);
        chk("s_pc",   s_pc,   acc ? m_pc   : 32'd0);
        chk("m0_rdy", {31'd0, m0_rdy}, {31'd0, done && !m_g});
        chk("m1_rdy", {31'd0, m1_rdy}, {31'd0, done && m_g});
        chk("m0_rd",  m0_rd, (done && !m_g) ? exp_rd : 32'd0);
        chk("m1_rd",  m1_rd, (done && m_g)  ? exp_rd : 32'd0);
        chk("m0_err", {31'd0, m0_err}, {31'd0, done && !m_g && exp_err});
        chk("m1_err", {31'd0, m1_err}, {31'd0, done && m_g && exp_err});
        if (m0_rdy || m1_rdy) begin
            rq_cyc.push_back(cyc);
            rq_who.push_back(m1_rdy);
            rq_dat.push_back(m1_rdy ? m1_rd : m0_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic m, input logic we, input logic [3:0] t,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
        if (!m) begin
            m0_req = 1; m0_we = we; m0_type = t; m0_addr = a; m0_wd = wd; m0_pc = pc;
        end else begin
            m1_req = 1; m1_we = we; m1_type = t; m1_addr = a; m1_wd = wd; m1_pc = pc;
        end
    endtask

    task automatic xact(input logic m, input logic we, input logic [3:0] t, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err);
        bit got = 0;
        drive(m, we, t, a, wd, a + 32'h400);
        tick();
        m0_req = 0; m1_req = 0;
        rd = '0; err = 0;
        repeat (20) if (!got) begin
            @(negedge clk);
            if (m ? m1_rdy : m0_rdy) begin
                got = 1;
                rd  = m ? m1_rd  : m0_rd;
                err = m ? m1_err : m0_err;
            end
        end
        chk("xact_done_within_bound", {31'd0, got}, 32'd1);
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          wc, nr;

        #22 rst = 0;
        #1;
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_rdy",    {30'd0, m0_rdy, m1_rdy}, 32'd0);
        chk("rst_rd",     m0_rd | m1_rd,   32'd0);
        chk("rst_s_addr", s_addr,          32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        tick();

        // m0 store word: s_we only in cycle 2, rdy in cycle 3
        wc = we_cnt;
        drive(0, 1, 4'b0000, 32'h10, 32'hDEAD_BEEF, 32'h100);
        tick(); m0_req = 0; #1;
        chk("st_c1_s_we", {31'd0, s_we}, 32'd0);
        chk("st_c1_addr", s_addr, 32'h10);
        tick(); #1;
        chk("st_c2_s_we", {31'd0, s_we}, 32'd1);
        chk("st_c2_wd",   s_wd, 32'hDEAD_BEEF);
        tick(); #1;
        chk("st_c3_m0_rdy", {31'd0, m0_rdy}, 32'd1);
        chk("st_c3_m1_rdy", {31'd0, m1_rdy}, 32'd0);
        chk("st_c3_s_we",   {31'd0, s_we},   32'd0);
        tick(); #1;
        chk("st_c4_m0_rdy", {31'd0, m0_rdy}, 32'd0);
        chk("st_we_pulses", 32'(we_cnt - wc), 32'd1);

        // m0 load word back
        xact(0, 0, 4'b0000, 32'h10, 32'h0, rd, err);
        chk("ld_rd",  rd, 32'hDEAD_BEEF);
        chk("ld_err", {31'd0, err}, 32'd0);

        // m1 misaligned half store: one s_we pulse, err reported, DM unchanged
        wc = we_cnt;
        xact(1, 1, 4'b0010, 32'h13, 32'h1234_5678, rd, err);
        chk("exc_err",       {31'd0, err}, 32'd1);
        chk("exc_we_pulses", 32'(we_cnt - wc), 32'd1);
        chk("exc_mem_word",  mem[4], 32'hDEAD_BEEF);

        // both masters request continuously: m0, m1, m0, m1, 4 cycles apart
        rq_cyc.delete(); rq_who.delete(); rq_dat.delete();
        drive(0, 0, 4'b0000, 32'h10, 32'h0, 32'h200);
        drive(1, 0, 4'b0000, 32'h20, 32'h0, 32'h300);
        repeat (40) if (rq_who.size() < 4) @(posedge clk);
        #1;
        m0_req = 0; m1_req = 0;
        chk("alt_count", 32'(rq_who.size()), 32'd4);
        if (rq_who.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("alt_who", {31'd0, rq_who[i]}, 32'(i % 2));
            for (int i = 1; i < 4; i++) chk("alt_spacing", 32'(rq_cyc[i] - rq_cyc[i-1]), 32'd4);
            chk("alt_m0_data", rq_dat[0], 32'hDEAD_BEEF);
            chk("alt_m1_data", rq_dat[1], 32'h1000_0008);
        end
        tick(); tick();

        // reset during cycle-1 ACCESS of a store
        wc = we_cnt;
        nr = rq_who.size();
        drive(0, 1, 4'b0000, 32'h20, 32'hCAFE_F00D, 32'h500);
        tick(); m0_req = 0;
        #1 rst = 1;
        #1;
        chk("mid_rst_busy",   {31'd0, busy},   32'd0);
        chk("mid_rst_s_we",   {31'd0, s_we},   32'd0);
        chk("mid_rst_s_addr", s_addr,          32'd0);
        chk("mid_rst_rdy",    {31'd0, m0_rdy}, 32'd0);
        #3 rst = 0;
        repeat (6) tick();
        chk("mid_rst_no_we",  32'(we_cnt - wc), 32'd0);
        chk("mid_rst_no_rdy", 32'(rq_who.size() - nr), 32'd0);
        chk("mid_rst_mem",    mem[8], 32'h1000_0008);

        // fresh request after reset completes normally
        xact(0, 1, 4'b0000, 32'h20, 32'hCAFE_F00D, rd, err);
        chk("post_rst_err", {31'd0, err}, 32'd0);
        chk("post_rst_mem", mem[8], 32'hCAFE_F00D);

        // WAIT_CYCLES=0 instance: m1 byte load, rdy in cycle 2 with cycle-1 s_rd
        m1_req_b = 1; m1_type_b = 4'b0100; m1_addr_b = 32'h11;
        tick(); m1_req_b = 0; #1;
        chk("w0_c1_addr", s_addr_b, 32'h11);
        chk("w0_c1_type", {28'd0, s_type_b}, 32'd4);
        chk("w0_c1_rdy",  {31'd0, m1_rdy_b}, 32'd0);
        tick(); #1;
        chk("w0_c2_rdy",    {31'd0, m1_rdy_b}, 32'd1);
        chk("w0_c2_rd",     m1_rd_b, 32'h5A5A_0011);
        chk("w0_c2_m0_rdy", {31'd0, m0_rdy_b}, 32'd0);
        chk("w0_c2_err",    {31'd0, m1_err_b}, 32'd0);
        tick(); #1;
        chk("w0_c3_rdy",  {31'd0, m1_rdy_b}, 32'd0);
        chk("w0_c3_busy", {31'd0, busy_b},   32'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
